// File: rtl/seg7_time_display_if.sv
// Bundles the time inputs and the multiplexed 7-segment outputs of seg7_time_display.
// The master side drives sec/min/hr; the slave side (the display) drives the digit outputs.
interface seg7_time_display_if;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    modport master (output sec, min, hr, input an, seg, dp, frame_start);
    modport slave  (input sec, min, hr, output an, seg, dp, frame_start);
endinterface

// File: rtl/seg7_time_display.sv
// Six-digit multiplexed HH:MM:SS display with per-frame input snapshot,
// blinking colon on the decimal points and an anti-ghosting blank window.
module seg7_time_display #(
    parameter int DIGIT_TICKS  = 100000,
    parameter int BLANK_CYCLES = 4,
    parameter bit HR_LZ_BLANK  = 1'b0
) (
    input logic           clk,
    input logic           rst,
    seg7_time_display_if.slave bus
);
    localparam int TW = $clog2(DIGIT_TICKS);

    logic [TW-1:0] tick;
    logic [2:0]    digit;
    logic [5:0]    sec_s;
    logic [5:0]    min_s;
    logic [4:0]    hr_s;

    logic [5:0] field;
    logic       field_bad;
    logic [3:0] bcd;
    logic       blank;
    logic [5:0] an_nx;
    logic [6:0] seg_nx;
    logic       dp_nx;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    // Next-cycle digit outputs, derived from the pre-edge scan position and shadows.
    always_comb begin
        field     = '0;
        field_bad = 1'b0;
        case (digit)
            3'd0, 3'd1: begin
                field     = sec_s;
                field_bad = sec_s > 6'd59;
            end
            3'd2, 3'd3: begin
                field     = min_s;
                field_bad = min_s > 6'd59;
            end
            default: begin
                field     = {1'b0, hr_s};
                field_bad = hr_s > 5'd23;
            end
        endcase

        bcd    = digit[0] ? 4'(field / 6'd10) : 4'(field % 6'd10);
        blank  = tick < TW'(BLANK_CYCLES);
        an_nx  = ~(6'd1 << digit);
        seg_nx = field_bad ? 7'b0111111 : seg_code(bcd);
        dp_nx  = !(((digit == 3'd2) || (digit == 3'd4)) && !sec_s[0]);

        if (HR_LZ_BLANK && (digit == 3'd5) && !field_bad && (hr_s < 5'd10))
            seg_nx = '1;

        if (blank) begin
            an_nx  = '1;
            seg_nx = '1;
            dp_nx  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick            <= '0;
            digit           <= '0;
            sec_s           <= '0;
            min_s           <= '0;
            hr_s            <= '0;
            bus.an          <= '1;
            bus.seg         <= '1;
            bus.dp          <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            if (tick == TW'(DIGIT_TICKS - 1)) begin
                tick  <= '0;
                digit <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
            end else begin
                tick <= tick + TW'(1);
            end

            bus.frame_start <= (tick == '0) && (digit == '0);
            if ((tick == '0) && (digit == '0)) begin
                sec_s <= bus.sec;
                min_s <= bus.min;
                hr_s  <= bus.hr;
            end

            bus.an  <= an_nx;
            bus.seg <= seg_nx;
            bus.dp  <= dp_nx;
        end
    end
endmodule

// File: tb/tb_seg7_time_display.sv
// Randomized self-checking bench for seg7_time_display; two instances differ only in HR_LZ_BLANK.
module tb_seg7_time_display;
    localparam int DT = 8;
    localparam int BC = 2;
    localparam int FR = 6 * DT;
    localparam logic [6:0] CODES [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};
    localparam logic [6:0] DASH = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hr  = '0;

    int errors = 0;
    int checks = 0;

    seg7_time_display_if b0 ();
    seg7_time_display_if b1 ();

    assign b0.sec = sec;
    assign b0.min = min;
    assign b0.hr  = hr;
    assign b1.sec = sec;
    assign b1.min = min;
    assign b1.hr  = hr;

    seg7_time_display #(.DIGIT_TICKS(DT), .BLANK_CYCLES(BC), .HR_LZ_BLANK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0));
    seg7_time_display #(.DIGIT_TICKS(DT), .BLANK_CYCLES(BC), .HR_LZ_BLANK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    // Reference model: frame position since reset plus the values captured at frame start.
    int         pos = 0;
    int         prev_pos = 0;
    int         m_sec = 0;
    int         m_min = 0;
    int         m_hr  = 0;
    logic [5:0] e_an;
    logic [6:0] e_seg0;
    logic [6:0] e_seg1;
    logic       e_dp;
    logic       e_fs;

    function automatic logic [6:0] ref_seg(input int d, input bit lz);
        int v;
        int lim;
        int dv;
        v   = (d < 2) ? m_sec : (d < 4) ? m_min : m_hr;
        lim = (d < 4) ? 59 : 23;
        if (v > lim) return DASH;
        dv = (d % 2 == 1) ? v / 10 : v % 10;
        if (lz && d == 5 && v < 10) return 7'h7F;
        return CODES[dv];
    endfunction

    task automatic tick_clk();
        int d;
        int t;
        prev_pos = pos;
        if (rst) begin
            e_an = 6'h3F; e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
            pos = 0; m_sec = 0; m_min = 0; m_hr = 0;
        end else begin
            d = pos / DT;
            t = pos % DT;
            if (t < BC) begin
                e_an = 6'h3F; e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an   = ~(6'd1 << d);
                e_seg0 = ref_seg(d, 1'b0);
                e_seg1 = ref_seg(d, 1'b1);
                e_dp   = !((d == 2 || d == 4) && (m_sec % 2 == 0));
            end
            e_fs = (pos == 0);
            if (pos == 0) begin
                m_sec = int'(sec); m_min = int'(min); m_hr = int'(hr);
            end
            pos = (pos + 1) % FR;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sync_to(input int target);
        for (int i = 0; i < FR && pos != target; i++) tick_clk();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            checks++;
            if ({b0.an, b0.seg, b0.dp, b0.frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0} ||
                {b1.an, b1.seg, b1.dp, b1.frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold got an=%h seg=%b dp=%b fs=%b required an=3f seg=1111111 dp=1 fs=0",
                         b0.an, b0.seg, b0.dp, b0.frame_start);
            end
        end
        rst = 1'b0;
        tick_clk();
        checks++;
        if (b0.frame_start !== 1'b1 || b1.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_fs got %b/%b required 1", b0.frame_start, b1.frame_start);
        end
        for (int i = 1; i <= FR; i++) begin
            tick_clk();
            checks++;
            if (b0.frame_start !== (i == FR) || b1.frame_start !== (i == FR)) begin
                errors++;
                $display("FAIL reset_fs_period cycle=%0d got %b required %b", i, b0.frame_start, i == FR);
            end
        end
    endtask

    task automatic test_decode();
        logic [6:0] t2_seg [6];
        logic [5:0] t2_an  [6];
        t2_seg = '{7'b1111000, 7'b0110000, 7'b0010010, 7'b1000000, 7'b0011001, 7'b1111001};
        t2_an  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        sec = 6'd37; min = 6'd5; hr = 5'd14;
        sync_to(0);
        for (int i = 0; i < FR; i++) begin
            tick_clk();
            checks++;
            if ({b0.an, b0.seg, b0.dp, b0.frame_start} !== {e_an, e_seg0, e_dp, e_fs} ||
                {b1.an, b1.seg, b1.dp, b1.frame_start} !== {e_an, e_seg1, e_dp, e_fs}) begin
                errors++;
                $display("FAIL decode_model pos=%0d got=%h/%h required=%h/%h", prev_pos,
                         {b0.an, b0.seg, b0.dp, b0.frame_start}, {b1.an, b1.seg, b1.dp, b1.frame_start},
                         {e_an, e_seg0, e_dp, e_fs}, {e_an, e_seg1, e_dp, e_fs});
            end
            if (prev_pos % DT == 5) begin
                checks++;
                if (b0.seg !== t2_seg[prev_pos / DT] || b0.an !== t2_an[prev_pos / DT]) begin
                    errors++;
                    $display("FAIL decode_digit%0d got an=%h seg=%b required an=%h seg=%b", prev_pos / DT,
                             b0.an, b0.seg, t2_an[prev_pos / DT], t2_seg[prev_pos / DT]);
                end
            end
        end
    endtask

    task automatic test_tearing();
        sec = 6'd37; min = 6'd12; hr = 5'd9;
        sync_to(0);
        for (int i = 0; i < 2 * FR; i++) begin
            if (i == 3) sec = 6'd38;
            tick_clk();
            checks++;
            if ({b0.an, b0.seg, b0.dp, b0.frame_start} !== {e_an, e_seg0, e_dp, e_fs} ||
                {b1.an, b1.seg, b1.dp, b1.frame_start} !== {e_an, e_seg1, e_dp, e_fs}) begin
                errors++;
                $display("FAIL tearing_model pos=%0d got=%h/%h required=%h/%h", prev_pos,
                         {b0.an, b0.seg, b0.dp, b0.frame_start}, {b1.an, b1.seg, b1.dp, b1.frame_start},
                         {e_an, e_seg0, e_dp, e_fs}, {e_an, e_seg1, e_dp, e_fs});
            end
            if (prev_pos == 5 || prev_pos == 21) begin
                checks++;
                if (i < FR && (b0.seg !== 7'b1111000 && prev_pos == 5 || b0.dp !== 1'b1 && prev_pos == 21)) begin
                    errors++;
                    $display("FAIL tearing_old pos=%0d got seg=%b dp=%b required old 37", prev_pos, b0.seg, b0.dp);
                end else if (i >= FR && (b0.seg !== 7'b0000000 && prev_pos == 5 || b0.dp !== 1'b0 && prev_pos == 21)) begin
                    errors++;
                    $display("FAIL tearing_new pos=%0d got seg=%b dp=%b required new 38", prev_pos, b0.seg, b0.dp);
                end
            end
        end
    endtask

    task automatic test_range_blank();
        sec = 6'd60; min = 6'($urandom_range(0, 59)); hr = 5'd7;
        sync_to(0);
        for (int i = 0; i < FR; i++) begin
            tick_clk();
            checks++;
            if ({b0.an, b0.seg, b0.dp, b0.frame_start} !== {e_an, e_seg0, e_dp, e_fs} ||
                {b1.an, b1.seg, b1.dp, b1.frame_start} !== {e_an, e_seg1, e_dp, e_fs}) begin
                errors++;
                $display("FAIL range_model pos=%0d got=%h/%h required=%h/%h", prev_pos,
                         {b0.an, b0.seg, b0.dp, b0.frame_start}, {b1.an, b1.seg, b1.dp, b1.frame_start},
                         {e_an, e_seg0, e_dp, e_fs}, {e_an, e_seg1, e_dp, e_fs});
            end
            if (prev_pos == 5 || prev_pos == 13) begin
                checks++;
                if (b1.seg !== DASH) begin
                    errors++;
                    $display("FAIL range_dash pos=%0d got %b required %b", prev_pos, b1.seg, DASH);
                end
            end
            if (prev_pos == 45) begin
                checks++;
                if (b1.seg !== 7'h7F || b1.an !== 6'h1F || b0.seg !== 7'b1000000) begin
                    errors++;
                    $display("FAIL hr_lz_blank got lz seg=%b an=%h plain seg=%b required 1111111 1f 1000000",
                             b1.seg, b1.an, b0.seg);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [6:0] exp_b [6];
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin
                sec = 6'd59; min = 6'd59; hr = 5'd23;
                exp_b = '{CODES[9], CODES[5], CODES[9], CODES[5], CODES[3], CODES[2]};
            end else begin
                sec = 6'd0; min = 6'd0; hr = 5'd0;
                exp_b = '{CODES[0], CODES[0], CODES[0], CODES[0], CODES[0], CODES[0]};
            end
            sync_to(0);
            for (int i = 0; i < FR; i++) begin
                tick_clk();
                checks++;
                if ({b0.an, b0.seg, b0.dp, b0.frame_start} !== {e_an, e_seg0, e_dp, e_fs} ||
                    {b1.an, b1.seg, b1.dp, b1.frame_start} !== {e_an, e_seg1, e_dp, e_fs}) begin
                    errors++;
                    $display("FAIL boundary_model pos=%0d got=%h/%h required=%h/%h", prev_pos,
                             {b0.an, b0.seg, b0.dp, b0.frame_start}, {b1.an, b1.seg, b1.dp, b1.frame_start},
                             {e_an, e_seg0, e_dp, e_fs}, {e_an, e_seg1, e_dp, e_fs});
                end
                if (prev_pos % DT == 6) begin
                    checks++;
                    if (b0.seg !== exp_b[prev_pos / DT] ||
                        b0.dp !== ((f == 1) && (prev_pos / DT == 2 || prev_pos / DT == 4) ? 1'b0 : 1'b1)) begin
                        errors++;
                        $display("FAIL boundary_digit f=%0d d=%0d got seg=%b dp=%b required seg=%b", f,
                                 prev_pos / DT, b0.seg, b0.dp, exp_b[prev_pos / DT]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FR; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                sec = 6'($urandom_range(0, 63));
                min = 6'($urandom_range(0, 63));
                hr  = 5'($urandom_range(0, 31));
            end
            tick_clk();
            checks++;
            if ({b0.an, b0.seg, b0.dp, b0.frame_start} !== {e_an, e_seg0, e_dp, e_fs} ||
                {b1.an, b1.seg, b1.dp, b1.frame_start} !== {e_an, e_seg1, e_dp, e_fs}) begin
                errors++;
                $display("FAIL random pos=%0d got=%h/%h required=%h/%h", prev_pos,
                         {b0.an, b0.seg, b0.dp, b0.frame_start}, {b1.an, b1.seg, b1.dp, b1.frame_start},
                         {e_an, e_seg0, e_dp, e_fs}, {e_an, e_seg1, e_dp, e_fs});
            end
        end
    endtask

    task automatic test_midop_reset();
        sec = 6'd42; min = 6'd17; hr = 5'd20;
        sync_to(3 * DT + 5);
        rst = 1'b1;
        tick_clk();
        checks++;
        if (b0.an !== 6'h3F || b0.seg !== 7'h7F || b0.dp !== 1'b1 || b1.an !== 6'h3F) begin
            errors++;
            $display("FAIL midop_reset_blank got an=%h seg=%b dp=%b required an=3f seg=1111111 dp=1",
                     b0.an, b0.seg, b0.dp);
        end
        rst = 1'b0;
        for (int i = 0; i < DT + 2; i++) begin
            tick_clk();
            checks++;
            if ({b0.an, b0.seg, b0.dp, b0.frame_start} !== {e_an, e_seg0, e_dp, e_fs} ||
                {b1.an, b1.seg, b1.dp, b1.frame_start} !== {e_an, e_seg1, e_dp, e_fs}) begin
                errors++;
                $display("FAIL midop_model pos=%0d got=%h/%h required=%h/%h", prev_pos,
                         {b0.an, b0.seg, b0.dp, b0.frame_start}, {b1.an, b1.seg, b1.dp, b1.frame_start},
                         {e_an, e_seg0, e_dp, e_fs}, {e_an, e_seg1, e_dp, e_fs});
            end
            if (i == 0 || i == 2) begin
                checks++;
                if ((i == 0 && b0.frame_start !== 1'b1) || (i == 2 && (b0.an !== 6'h3E || b0.seg !== CODES[2]))) begin
                    errors++;
                    $display("FAIL midop_restart step=%0d got fs=%b an=%h seg=%b required restart at digit 0",
                             i, b0.frame_start, b0.an, b0.seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_tearing();
        test_range_blank();
        test_boundary();
        test_random();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
